alu_core_stage: RTL and testbench

//  Second ALU stage: consumes the registered Shift/LCarryOut of the LHS shift stage, combines it

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_core_stage_if.sv | 36 +++
 rtl/alu_addsub8.sv | 27 ++
 rtl/alu_core_stage.sv | 166 ++++++++++++++++
 tb/tb_alu_core_stage.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the two-stage ALU: datapath width, op codes,
// the flag register layout and small op-classification helpers.
package alu_pkg;

  // Datapath width; the LHS stage and adder are fixed at 8 bits.
  localparam int ALU_W = 8;

  // Op codes carried on AluOp.
  localparam logic [3:0] ALU_OP_PASSL = 4'h0;
  localparam logic [3:0] ALU_OP_ADD   = 4'h1;
  localparam logic [3:0] ALU_OP_ADC   = 4'h2;
  localparam logic [3:0] ALU_OP_SUB   = 4'h3;
  localparam logic [3:0] ALU_OP_SBC   = 4'h4;
  localparam logic [3:0] ALU_OP_AND   = 4'h5;
  localparam logic [3:0] ALU_OP_OR    = 4'h6;
  localparam logic [3:0] ALU_OP_XOR   = 4'h7;
  localparam logic [3:0] ALU_OP_NOTL  = 4'h8;
  localparam logic [3:0] ALU_OP_PASSR = 4'h9;
  localparam logic [3:0] ALU_OP_CMP   = 4'hA;
  localparam logic [3:0] ALU_OP_RSV_B = 4'hB;
  localparam logic [3:0] ALU_OP_RSV_C = 4'hC;
  localparam logic [3:0] ALU_OP_RSV_D = 4'hD;
  localparam logic [3:0] ALU_OP_RSV_E = 4'hE;
  localparam logic [3:0] ALU_OP_RSV_F = 4'hF;

  // Flag register: carry, zero, negative, overflow.
  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } alu_flags_t;

  // Codes above CMP are reserved and must leave all state untouched.
  function automatic logic alu_op_reserved(input logic [3:0] op);
    return (op > ALU_OP_CMP);
  endfunction

  // Ops that run the adder in subtract mode (b inverted).
  function automatic logic alu_op_is_sub(input logic [3:0] op);
    return (op == ALU_OP_SUB) || (op == ALU_OP_SBC) || (op == ALU_OP_CMP);
  endfunction

endpackage

// File: rtl/alu_core_stage_if.sv
// Bus between the LHS shift stage / issue logic and the ALU core stage.
// Valid/ready note: there is no ready; the core accepts one op per cycle
// unconditionally. OpValid qualifies AluOp, RHS and FlagsWe in the cycle they
// are presented; ResultValid marks the single cycle in which Result holds a
// newly retired op. Shift/LCarryOut are the LHS stage's registered outputs
// and line up with the op one cycle after AluOp was presented.
interface alu_core_stage_if;
  import alu_pkg::*;

  logic [ALU_W-1:0] Shift;
  logic             LCarryOut;
  logic [ALU_W-1:0] RHS;
  logic [3:0]       AluOp;
  logic             OpValid;
  logic             FlagsWe;
  logic [ALU_W-1:0] Result;
  logic             ResultValid;
  logic             FlagC;
  logic             FlagZ;
  logic             FlagN;
  logic             FlagV;
  logic             LCarryIn;

  // Issue side: the LHS stage and op sequencer.
  modport master (
    output Shift, LCarryOut, RHS, AluOp, OpValid, FlagsWe,
    input  Result, ResultValid, FlagC, FlagZ, FlagN, FlagV, LCarryIn
  );

  // The ALU core stage itself.
  modport slave (
    input  Shift, LCarryOut, RHS, AluOp, OpValid, FlagsWe,
    output Result, ResultValid, FlagC, FlagZ, FlagN, FlagV, LCarryIn
  );

endinterface

// File: rtl/alu_addsub8.sv
// 8-bit adder/subtractor shared by ADD, ADC, SUB, SBC and CMP.
// Subtraction is a + ~b + cin, so cout=1 means "no borrow". Overflow is
// judged on the effective (possibly inverted) b operand.
module alu_addsub8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [7:0] sum,
  output logic       cout,
  output logic       ovf
);

  logic [7:0] b_eff;
  logic [8:0] total;

  // Invert b for subtract ops and form the 9-bit sum.
  always_comb begin
    b_eff = sub ? ~b : b;
    total = {1'b0, a} + {1'b0, b_eff} + {8'd0, cin};
  end

  assign sum  = total[7:0];
  assign cout = total[8];
  assign ovf  = (a[7] == b_eff[7]) & (sum[7] != a[7]);

endmodule

// File: rtl/alu_core_stage.sv
// Second ALU stage: registers the op controls, combines the LHS stage's
// registered Shift/LCarryOut with the RHS operand and retires Result plus the
// C/Z/N/V flag register one edge later (two edges after the op is presented).
// Optional feature macro: ALU_FLAG_BYPASS_EN -- when defined, LCarryIn forwards
// the carry being produced by the op currently in flight instead of waiting
// for it to land in FlagC.
module alu_core_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input logic           AluClock,
  input logic           Reset,
  alu_core_stage_if.slave bus
);

  // Control registers captured at E1, alongside the LHS stage's Shift.
  logic [3:0]       op_q;
  logic [WIDTH-1:0] rhs_q;
  logic             v_q;
  logic             we_q;

  // Retired state.
  logic [WIDTH-1:0] result_q;
  logic             result_valid_q;
  alu_flags_t       flags_q;

  // Compute-cycle signals.
  logic [WIDTH-1:0] res;
  logic             res_wr;
  logic             flag_wr;
  alu_flags_t       next_flags;

  logic [WIDTH-1:0] as_sum;
  logic             as_cout;
  logic             as_ovf;
  logic             as_cin;
  logic             as_sub;

  // Capture the op controls; reset drops whatever was about to enter compute.
  always_ff @(posedge AluClock) begin
    if (Reset) begin
      op_q  <= ALU_OP_PASSL;
      rhs_q <= '0;
      v_q   <= 1'b0;
      we_q  <= 1'b0;
    end else begin
      op_q  <= bus.AluOp;
      rhs_q <= bus.RHS;
      v_q   <= bus.OpValid;
      we_q  <= bus.FlagsWe;
    end
  end

  // Carry-in selection: plain ADD has none, SUB/CMP use 1 (two's complement),
  // ADC/SBC chain the carry currently held in FlagC.
  always_comb begin
    as_sub = alu_op_is_sub(op_q);
    as_cin = 1'b0;
    case (op_q)
      ALU_OP_ADD:             as_cin = 1'b0;
      ALU_OP_SUB, ALU_OP_CMP: as_cin = 1'b1;
      ALU_OP_ADC, ALU_OP_SBC: as_cin = flags_q.c;
      default:                as_cin = 1'b0;
    endcase
  end

  alu_addsub8 u_addsub (
    .a    (bus.Shift),
    .b    (rhs_q),
    .cin  (as_cin),
    .sub  (as_sub),
    .sum  (as_sum),
    .cout (as_cout),
    .ovf  (as_ovf)
  );

  // Op decode: pick the result and the candidate flag values for this op.
  // PASSL and the logic ops take C from the LHS shift-out and clear V.
  always_comb begin
    res          = result_q;
    res_wr       = 1'b0;
    flag_wr      = 1'b0;
    next_flags   = flags_q;
    case (op_q)
      ALU_OP_PASSL: begin
        res          = bus.Shift;
        res_wr       = 1'b1;
        flag_wr      = 1'b1;
        next_flags.c = bus.LCarryOut;
        next_flags.v = 1'b0;
      end
      ALU_OP_ADD, ALU_OP_ADC, ALU_OP_SUB, ALU_OP_SBC: begin
        res          = as_sum;
        res_wr       = 1'b1;
        flag_wr      = 1'b1;
        next_flags.c = as_cout;
        next_flags.v = as_ovf;
      end
      ALU_OP_CMP: begin
        // Flags as SUB, but Result is left alone.
        res          = as_sum;
        res_wr       = 1'b0;
        flag_wr      = 1'b1;
        next_flags.c = as_cout;
        next_flags.v = as_ovf;
      end
      ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR, ALU_OP_NOTL, ALU_OP_PASSR: begin
        case (op_q)
          ALU_OP_AND:  res = bus.Shift & rhs_q;
          ALU_OP_OR:   res = bus.Shift | rhs_q;
          ALU_OP_XOR:  res = bus.Shift ^ rhs_q;
          ALU_OP_NOTL: res = ~bus.Shift;
          default:     res = rhs_q;
        endcase
        res_wr       = 1'b1;
        flag_wr      = 1'b1;
        next_flags.c = bus.LCarryOut;
        next_flags.v = 1'b0;
      end
      default: begin
        // Reserved codes: no result, no flag update.
        res_wr  = 1'b0;
        flag_wr = 1'b0;
      end
    endcase
    next_flags.z = (res == '0);
    next_flags.n = res[WIDTH-1];
  end

  // Retire at E2: Result only moves for result-writing ops, flags only when
  // the op asked for it and is not reserved.
  always_ff @(posedge AluClock) begin
    if (Reset) begin
      result_q       <= '0;
      result_valid_q <= 1'b0;
      flags_q        <= '0;
    end else begin
      result_valid_q <= v_q & res_wr;
      if (v_q && res_wr) begin
        result_q <= res;
      end
      if (v_q && we_q && flag_wr) begin
        flags_q <= next_flags;
      end
    end
  end

  assign bus.Result      = result_q;
  assign bus.ResultValid = result_valid_q;
  assign bus.FlagC       = flags_q.c;
  assign bus.FlagZ       = flags_q.z;
  assign bus.FlagN       = flags_q.n;
  assign bus.FlagV       = flags_q.v;

`ifdef ALU_FLAG_BYPASS_EN
  // Forward the carry of the op being retired this cycle so the LHS stage
  // can rotate through it without a bubble.
  assign bus.LCarryIn = (v_q & we_q & flag_wr) ? next_flags.c : flags_q.c;
`else
  // Registered carry only; a carry-setting op needs one bubble before a
  // dependent rotate-through-carry.
  assign bus.LCarryIn = flags_q.c;
`endif

endmodule

// File: tb/tb_alu_core_stage.sv
// Bench for alu_core_stage: directed cases with hand-computed results, then
// randomized traffic with occasional resets, checked every cycle against a
// transaction-level arithmetic model. Honors ALU_FLAG_BYPASS_EN when defined.
module tb_alu_core_stage;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic AluClock = 1'b0;
  logic Reset    = 1'b1;
  always #5 AluClock = ~AluClock;

  alu_core_stage_if bus ();

  alu_core_stage dut (
    .AluClock (AluClock),
    .Reset    (Reset),
    .bus      (bus)
  );

  // Stand-in for the LHS stage: registers the operand presented with the op.
  logic [7:0] lhs_next = 8'h00;
  logic       lc_next  = 1'b0;
  logic [7:0] shift_q;
  logic       lc_q;
  always_ff @(posedge AluClock) begin
    shift_q <= lhs_next;
    lc_q    <= lc_next;
  end
  assign bus.Shift     = shift_q;
  assign bus.LCarryOut = lc_q;

  // ---------------- counters / check ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] op;
    logic [7:0] l;
    logic       lc;
    logic [7:0] r;
    logic       v;
    logic       we;
  } txn_t;

  txn_t       pend[$];
  logic [7:0] exp_q[$];
  int         m_result = 0;
  bit         m_valid  = 0;
  bit         m_c = 0, m_z = 0, m_n = 0, m_v = 0;
  bit         exp_lcin = 0;
  bit         live = 0;

  // Plain-arithmetic meaning of each op. fc is the carry flag before the op.
  function automatic void evaluate(input txn_t t, input bit fc, output int res,
                                   output bit wr_res, output bit wr_flags,
                                   output bit c, output bit v);
    int l, r, sl, sr, s, sv, bw;
    l  = int'(t.l);
    r  = int'(t.r);
    sl = (l > 127) ? l - 256 : l;
    sr = (r > 127) ? r - 256 : r;
    res = 0; wr_res = 0; wr_flags = 0; c = 0; v = 0;
    case (t.op)
      4'h0: begin res = l; c = t.lc; wr_res = 1; wr_flags = 1; end
      4'h1, 4'h2: begin
        bw  = (t.op == 4'h2) ? int'(fc) : 0;
        s   = l + r + bw;
        sv  = sl + sr + bw;
        res = s % 256;
        c   = (s > 255);
        v   = (sv > 127) || (sv < -128);
        wr_res = 1; wr_flags = 1;
      end
      4'h3, 4'h4, 4'hA: begin
        bw  = (t.op == 4'h4) ? (fc ? 0 : 1) : 0;
        s   = l - r - bw;
        sv  = sl - sr - bw;
        res = ((s % 256) + 256) % 256;
        c   = (s >= 0);
        v   = (sv > 127) || (sv < -128);
        wr_res = (t.op != 4'hA); wr_flags = 1;
      end
      4'h5: begin res = l & r;     c = t.lc; wr_res = 1; wr_flags = 1; end
      4'h6: begin res = l | r;     c = t.lc; wr_res = 1; wr_flags = 1; end
      4'h7: begin res = l ^ r;     c = t.lc; wr_res = 1; wr_flags = 1; end
      4'h8: begin res = 255 - l;   c = t.lc; wr_res = 1; wr_flags = 1; end
      4'h9: begin res = r;         c = t.lc; wr_res = 1; wr_flags = 1; end
      default: begin end
    endcase
  endfunction

  // Model advances on every active edge: retire last cycle's op, accept this one.
  always @(posedge AluClock) begin
    txn_t t;
    int   res;
    bit   wr_res, wr_flags, c, v;
    if (Reset) begin
      pend.delete();
      exp_q.delete();
      m_result = 0; m_valid = 0;
      m_c = 0; m_z = 0; m_n = 0; m_v = 0;
      exp_lcin = 0;
      live = 1;
    end else begin
      m_valid = 0;
      if (pend.size() > 0) begin
        t = pend.pop_front();
        if (t.v) begin
          evaluate(t, m_c, res, wr_res, wr_flags, c, v);
          m_valid = wr_res;
          if (wr_res) begin
            m_result = res;
            exp_q.push_back(8'(res));
          end
          if (wr_flags && t.we) begin
            m_c = c; m_v = v;
            m_z = (res == 0);
            m_n = (res >= 128);
          end
        end
      end
      pend.push_back('{op: bus.AluOp, l: lhs_next, lc: lc_next, r: bus.RHS,
                       v: bus.OpValid, we: bus.FlagsWe});
      exp_lcin = m_c;
`ifdef ALU_FLAG_BYPASS_EN
      if (pend[0].v && pend[0].we) begin
        evaluate(pend[0], m_c, res, wr_res, wr_flags, c, v);
        if (wr_flags) exp_lcin = c;
      end
`endif
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge AluClock) begin
    logic [7:0] exp_r;
    if (live) begin
      check("result_valid", int'(bus.ResultValid), int'(m_valid));
      if (bus.ResultValid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_retire", 1, 0);
        end else begin
          exp_r = exp_q.pop_front();
          check("retired_result", int'(bus.Result), int'(exp_r));
        end
      end
      check("result_hold", int'(bus.Result), m_result);
      check("flag_c", int'(bus.FlagC), int'(m_c));
      check("flag_z", int'(bus.FlagZ), int'(m_z));
      check("flag_n", int'(bus.FlagN), int'(m_n));
      check("flag_v", int'(bus.FlagV), int'(m_v));
      check("lcarry_in", int'(bus.LCarryIn), int'(exp_lcin));
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [3:0] op, input logic [7:0] l, input logic lc,
                       input logic [7:0] r, input logic v, input logic we);
    bus.AluOp   = op;
    lhs_next    = l;
    lc_next     = lc;
    bus.RHS     = r;
    bus.OpValid = v;
    bus.FlagsWe = we;
    @(negedge AluClock);
  endtask

  task automatic idle();
    drive(4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_flags(input string name, input int c, input int z,
                             input int n, input int v);
    check({name, "_c"}, int'(bus.FlagC), c);
    check({name, "_z"}, int'(bus.FlagZ), z);
    check({name, "_n"}, int'(bus.FlagN), n);
    check({name, "_v"}, int'(bus.FlagV), v);
  endtask

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.AluOp = 4'h0; bus.RHS = 8'h00; bus.OpValid = 1'b0; bus.FlagsWe = 1'b0;
    Reset = 1'b1;
    @(negedge AluClock);
    repeat (3) idle();
    Reset = 1'b0;
    check("reset_result", int'(bus.Result), 0);
    check("reset_valid", int'(bus.ResultValid), 0);
    check_flags("reset", 0, 0, 0, 0);

    // 0xFF + 0x01 wraps to zero with carry.
    drive(ALU_OP_ADD, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b1);
    check("add_wrap_not_yet", int'(bus.ResultValid), 0);
    idle();
    check("add_wrap_valid", int'(bus.ResultValid), 1);
    check("add_wrap_result", int'(bus.Result), 8'h00);
    check_flags("add_wrap", 1, 1, 0, 0);

    // SUB 0x10-0x20 then CMP 0x20/0x20 back-to-back.
    drive(ALU_OP_SUB, 8'h10, 1'b0, 8'h20, 1'b1, 1'b1);
    drive(ALU_OP_CMP, 8'h20, 1'b0, 8'h20, 1'b1, 1'b1);
    check("sub_result", int'(bus.Result), 8'hF0);
    check_flags("sub", 0, 0, 1, 0);
    idle();
    check("cmp_valid", int'(bus.ResultValid), 0);
    check("cmp_result_kept", int'(bus.Result), 8'hF0);
    check_flags("cmp", 1, 1, 0, 0);

    // 0x7F + 0x01 overflows; ADC right behind it sees C=0.
    drive(ALU_OP_ADD, 8'h7F, 1'b0, 8'h01, 1'b1, 1'b1);
    drive(ALU_OP_ADC, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    check("ovf_result", int'(bus.Result), 8'h80);
    check_flags("ovf", 0, 0, 1, 1);
    idle();
    check("adc_result", int'(bus.Result), 8'h00);
    check_flags("adc", 0, 1, 0, 0);

    // LHS shifted 0x81 left: Shift=0x02, shift-out=1, passed through.
    drive(ALU_OP_PASSL, 8'h02, 1'b1, 8'h00, 1'b1, 1'b1);
`ifdef ALU_FLAG_BYPASS_EN
    check("lcin_bypass_early", int'(bus.LCarryIn), 1);
`else
    check("lcin_registered_early", int'(bus.LCarryIn), 0);
`endif
    idle();
    check("passl_result", int'(bus.Result), 8'h02);
    check("passl_c", int'(bus.FlagC), 1);
    check("lcin_late", int'(bus.LCarryIn), 1);

    // Invalid op and reserved op leave everything alone.
    drive(ALU_OP_ADD, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    drive(ALU_OP_RSV_C, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    idle();
    check("reserved_valid", int'(bus.ResultValid), 0);
    idle();
    check("reserved_result", int'(bus.Result), 8'h02);
    check_flags("reserved", 1, 0, 0, 0);

    // Reset while an ADD is in flight: it must never retire.
    drive(ALU_OP_ADD, 8'h01, 1'b0, 8'h01, 1'b1, 1'b1);
    Reset = 1'b1;
    repeat (3) idle();
    Reset = 1'b0;
    check("midreset_result", int'(bus.Result), 0);
    check("midreset_valid", int'(bus.ResultValid), 0);
    check_flags("midreset", 0, 0, 0, 0);
    idle();
    check("midreset_no_retire", int'(bus.ResultValid), 0);

    // Randomized traffic, mostly valid ops, occasional resets.
    repeat (600) begin
      Reset = ($urandom_range(0, 79) == 0);
      drive(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end
    Reset = 1'b0;
    repeat (3) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
